// File: rtl/scroll_ctrl_if.sv
// scroll_ctrl_if: message-memory, frame-shift and serializer handshake bundle
interface scroll_ctrl_if #(parameter int ADDR_W = 8);
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_data;
    logic              shift_en;
    logic              shift_dir;
    logic [7:0]        shift_d;
    logic              upd_req;
    logic              upd_ack;

    modport master (
        output mem_rd, mem_addr, shift_en, shift_dir, shift_d, upd_req,
        input  mem_data, upd_ack
    );

    modport slave (
        input  mem_rd, mem_addr, shift_en, shift_dir, shift_d, upd_req,
        output mem_data, upd_ack
    );
endinterface

// File: rtl/scroll_ctrl.sv
// scroll_ctrl: column sequencer feeding a scrolling-text frame register
module scroll_ctrl #(
    parameter int CLK_DIV = 1000000,
    parameter int ADDR_W  = 8,
    parameter int GAP     = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic              dir_in,
    input  logic [ADDR_W-1:0] msg_len,
    scroll_ctrl_if.master     bus,
    output logic              busy,
    output logic              wrap,
    output logic              overrun
);
    // pos must reach msg_len+GAP-1, which can exceed the address range
    localparam int PW = ADDR_W + $clog2(GAP + 2);
    localparam int CW = $clog2(CLK_DIV);

    typedef enum logic [2:0] {IDLE, READ, LATCH, SHIFT, UPDATE, WAIT_TICK} state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     pos_q, pos_d;
    logic [ADDR_W-1:0] len_q, len_d;
    logic [CW-1:0]     pre_q, pre_d;
    logic [7:0]        col_q, col_d;
    logic              dir_q, dir_d;
    logic              tick_pend_q, tick_pend_d;
    logic              stop_pend_q, stop_pend_d;
    logic              overrun_q, overrun_d;
    logic              idle, go, tick, data_col, last;
    logic [ADDR_W-1:0] addr;

    assign idle     = state_q == IDLE;
    assign go       = idle && start && msg_len != '0;
    assign tick     = !idle && pre_q == CW'(CLK_DIV - 1);
    assign data_col = pos_q < PW'(len_q);
    assign last     = pos_q == PW'(len_q) + PW'(GAP) - PW'(1);
    assign addr     = dir_q ? len_q - ADDR_W'(1) - pos_q[ADDR_W-1:0] : pos_q[ADDR_W-1:0];

    // state and datapath registers, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pos_q       <= '0;
            len_q       <= '0;
            pre_q       <= '0;
            col_q       <= '0;
            dir_q       <= 1'b0;
            tick_pend_q <= 1'b0;
            stop_pend_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pos_q       <= pos_d;
            len_q       <= len_d;
            pre_q       <= pre_d;
            col_q       <= col_d;
            dir_q       <= dir_d;
            tick_pend_q <= tick_pend_d;
            stop_pend_q <= stop_pend_d;
            overrun_q   <= overrun_d;
        end
    end

    // next-state: one column per pass READ->LATCH->SHIFT->UPDATE, then wait for a tick
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      state_d = go ? READ : IDLE;
            READ:      state_d = LATCH;
            LATCH:     state_d = SHIFT;
            SHIFT:     state_d = UPDATE;
            UPDATE:    state_d = bus.upd_ack ? (stop_pend_q ? IDLE : WAIT_TICK) : UPDATE;
            WAIT_TICK: state_d = (tick || tick_pend_q) ? READ : WAIT_TICK;
            default:   state_d = IDLE;
        endcase
    end

    // datapath: position, prescaler, pending tick/stop bookkeeping and column capture
    always_comb begin
        len_d       = go ? msg_len : len_q;
        dir_d       = go ? dir_in : dir_q;
        pos_d       = go ? '0 : state_q == SHIFT ? (last ? '0 : pos_q + PW'(1)) : pos_q;
        pre_d       = (idle || tick) ? '0 : pre_q + CW'(1);
        col_d       = state_q == LATCH ? (data_col ? bus.mem_data : 8'h00) : col_q;
        overrun_d   = go ? 1'b0 : overrun_q | (tick && tick_pend_q && state_q != WAIT_TICK);
        tick_pend_d = idle ? 1'b0 : state_q == WAIT_TICK ? tick && tick_pend_q : tick_pend_q | tick;
        stop_pend_d = !idle && state_d != IDLE && (stop || stop_pend_q);
    end

    // outputs decoded from the current state
    always_comb begin
        busy          = !idle;
        bus.mem_rd    = state_q == READ && data_col;
        bus.mem_addr  = bus.mem_rd ? addr : '0;
        bus.shift_en  = state_q == SHIFT;
        bus.shift_d   = col_q;
        bus.shift_dir = dir_q;
        bus.upd_req   = state_q == UPDATE;
        wrap          = state_q == SHIFT && last;
        overrun       = overrun_q;
    end
endmodule

// File: tb/tb_scroll_ctrl.sv
// tb_scroll_ctrl: directed scoreboard bench for scroll_ctrl
module tb_scroll_ctrl;
    localparam int CLK_DIV = 8;
    localparam int GAP     = 2;
    localparam int AW      = 8;

    typedef struct packed {
        logic [7:0] d;
        logic       w;
        logic       dr;
    } col_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          dir_in = 1'b0;
    logic [AW-1:0] msg_len = '0;
    logic          busy, wrap, overrun;

    scroll_ctrl_if #(.ADDR_W(AW)) bus();

    scroll_ctrl #(.CLK_DIV(CLK_DIV), .ADDR_W(AW), .GAP(GAP)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .dir_in(dir_in),
        .msg_len(msg_len), .bus(bus), .busy(busy), .wrap(wrap), .overrun(overrun)
    );

    always #5 clk = ~clk;

    col_t          exp_q[$];
    logic [AW-1:0] addr_q[$];
    logic [7:0]    mem [0:255];
    int n_pass = 0, n_tot = 0, n_shift = 0, n_req = 0, req_cnt = 0, req_len = 0;
    int ack_dly = 1, last_sh = -1, cycle = 0, n0 = 0, r0 = 0;
    bit spacing_chk = 0;

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        n_tot++;
        assert (o === e) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    endtask

    task automatic push(input logic [7:0] d, input logic w, input logic dr);
        col_t c;
        c.d = d; c.w = w; c.dr = dr;
        exp_q.push_back(c);
    endtask

    // one clock: sample at negedge, score outputs, then play memory and serializer
    task automatic cyc();
        col_t c;
        @(negedge clk);
        cycle++;
        if (bus.shift_en) begin
            n_shift++;
            if (exp_q.size() == 0) chk("unexpected_shift", 32'(bus.shift_en), 0);
            else begin
                c = exp_q.pop_front();
                chk("shift_d", 32'(bus.shift_d), 32'(c.d));
                chk("wrap", 32'(wrap), 32'(c.w));
                chk("shift_dir", 32'(bus.shift_dir), 32'(c.dr));
            end
            if (spacing_chk && last_sh >= 0) chk("spacing", cycle - last_sh, CLK_DIV);
            last_sh = cycle;
        end else if (wrap) chk("wrap_outside_shift", 32'(wrap), 0);
        if (bus.mem_rd) begin
            if (addr_q.size() == 0) chk("unexpected_rd", 32'(bus.mem_rd), 0);
            else chk("mem_addr", 32'(bus.mem_addr), 32'(addr_q.pop_front()));
        end
        if (bus.upd_req && req_cnt == 0) n_req++;
        if (!bus.upd_req && req_cnt != 0) req_len = req_cnt;
        bus.upd_ack = bus.upd_req && req_cnt == ack_dly;
        req_cnt = bus.upd_req ? req_cnt + 1 : 0;
        if (bus.mem_rd) bus.mem_data = mem[bus.mem_addr];
    endtask

    task automatic chk_zero(input string tag);
        chk(tag, 32'({busy, wrap, overrun, bus.mem_rd, bus.shift_en, bus.upd_req,
                      bus.shift_dir, bus.shift_d, bus.mem_addr}), 0);
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 200 && busy; i++) cyc();
        chk(tag, 32'(busy), 0);
        chk({tag, "_cols_left"}, exp_q.size(), 0);
        chk({tag, "_rds_left"}, addr_q.size(), 0);
    endtask

    task automatic do_start(input logic d, input logic [AW-1:0] len);
        dir_in = d; msg_len = len; start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        cyc();
        stop = 1'b0;
    endtask

    initial begin
        bus.upd_ack = 1'b0;
        bus.mem_data = '0;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i * 7 + 1);
        mem[0] = 8'hA5; mem[1] = 8'h3C; mem[2] = 8'hFF;
        repeat (3) cyc();
        chk_zero("reset_outputs");
        rst_n = 1'b1;
        cyc();

        // forward pass with gap and wrap, steady 8-cycle spacing
        push(8'hA5, 0, 0); push(8'h3C, 0, 0); push(8'hFF, 0, 0);
        push(8'h00, 0, 0); push(8'h00, 1, 0); push(8'hA5, 0, 0);
        addr_q.push_back(0); addr_q.push_back(1); addr_q.push_back(2); addr_q.push_back(0);
        spacing_chk = 1; last_sh = -1; n_shift = 0;
        do_start(1'b0, 8'd3);
        chk("rd_at_k1", 32'(bus.mem_rd), 1);
        chk("busy_at_k1", 32'(busy), 1);
        cyc();
        chk("no_shift_at_k2", 32'(bus.shift_en), 0);
        cyc();
        chk("shift_at_k3", 32'(bus.shift_en), 1);
        cyc();
        chk("req_at_k4", 32'(bus.upd_req), 1);
        for (int i = 0; i < 200 && n_shift < 6; i++) cyc();
        chk("t1_shifts", n_shift, 6);
        do_stop();
        wait_idle("t1_idle");
        spacing_chk = 0;

        // reverse pass
        push(8'hFF, 0, 1); push(8'h3C, 0, 1); push(8'hA5, 0, 1);
        push(8'h00, 0, 1); push(8'h00, 1, 1);
        addr_q.push_back(2); addr_q.push_back(1); addr_q.push_back(0);
        n_shift = 0;
        do_start(1'b1, 8'd3);
        for (int i = 0; i < 200 && n_shift < 5; i++) cyc();
        chk("t2_shifts", n_shift, 5);
        chk("t2_dir_held", 32'(bus.shift_dir), 1);
        do_stop();
        wait_idle("t2_idle");

        // zero-length message is ignored
        n0 = n_shift;
        do_start(1'b0, 8'd0);
        repeat (10) begin
            chk("len0_busy", 32'(busy), 0);
            cyc();
        end
        chk("len0_shifts", n_shift - n0, 0);

        // slow serializer: 20-cycle request, lost tick, pending tick replayed
        ack_dly = 19; req_len = 0;
        push(8'hA5, 0, 0); push(8'h3C, 0, 0);
        addr_q.push_back(0); addr_q.push_back(1);
        do_start(1'b0, 8'd3);
        for (int i = 0; i < 100 && req_len == 0; i++) cyc();
        chk("slow_req_len", req_len, 20);
        chk("slow_overrun", 32'(overrun), 1);
        cyc();
        chk("slow_pending_read", 32'(bus.mem_rd), 1);
        ack_dly = 1;
        do_stop();
        wait_idle("t4_idle");
        chk("overrun_sticky", 32'(overrun), 1);

        // stop while waiting for a tick: exactly one more column
        req_len = 0;
        push(8'hA5, 0, 0); push(8'h3C, 0, 0);
        addr_q.push_back(0); addr_q.push_back(1);
        do_start(1'b0, 8'd3);
        chk("overrun_cleared", 32'(overrun), 0);
        for (int i = 0; i < 100 && req_len == 0; i++) cyc();
        chk("t5_in_wait", 32'({busy, bus.upd_req}), 32'b10);
        n0 = n_shift; r0 = n_req;
        do_stop();
        wait_idle("t5_idle");
        chk("t5_one_shift", n_shift - n0, 1);
        chk("t5_one_req", n_req - r0, 1);

        // reset during an outstanding refresh request, then restart from pos 0
        ack_dly = 50;
        push(8'hFF, 0, 1);
        addr_q.push_back(2);
        do_start(1'b1, 8'd3);
        for (int i = 0; i < 20 && !bus.upd_req; i++) cyc();
        chk("t6_req_up", 32'(bus.upd_req), 1);
        rst_n = 1'b0;
        cyc();
        chk_zero("mid_reset_outputs");
        rst_n = 1'b1;
        ack_dly = 1;
        cyc();
        chk_zero("after_reset_idle");
        push(8'hA5, 0, 0);
        addr_q.push_back(0);
        do_start(1'b0, 8'd3);
        do_stop();
        wait_idle("t6_idle");

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule

// File: doc/scroll_ctrl.md
Name: scroll_ctrl

Overview:
Sequencer that drives the 16-column, 8-row (128-pixel) column-shift frame register for scrolling text on the dual 8x8 MAX7219 matrix.
- Paced by an internal prescaler tick.
- Fetches one 8-bit glyph column per step from an external message memory.
- Pulses the shift enable with that column and the scroll direction.
- Then requests a display refresh from the MAX7219 serializer and waits for its acknowledge.
- Inserts a configurable blank gap between message repetitions and loops until stopped.

Parameters:
CLK_DIV, 1000000, clk cycles between scroll ticks (>=2)
ADDR_W, 8, message memory address width
GAP, 8, zero columns inserted after each message pass (0 = none)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
start  in  1  single-cycle pulse: begin scrolling (ignored when busy or msg_len==0)
stop  in  1  single-cycle pulse: stop after the current column completes
dir_in  in  1  0 = columns enter right/shift left, message read ascending; 1 = mirror
msg_len  in  ADDR_W  number of message columns (sampled at start)
mem_rd  out  1  read strobe to message memory
mem_addr  out  ADDR_W  read address, valid while mem_rd=1
mem_data  in  8  column data, valid exactly 1 cycle after mem_rd
shift_en  out  1  one-cycle enable to the frame shift register
shift_dir  out  1  direction for the shift register, held stable while busy
shift_d  out  8  column data into the shift register, valid with shift_en
upd_req  out  1  refresh request to the serializer, level, held until upd_ack
upd_ack  in  1  serializer accepted the frame
busy  out  1  high in every state except IDLE
wrap  out  1  one-cycle pulse when the column position returns to 0
overrun  out  1  sticky: a tick was lost; cleared by start or reset

Behaviour:
- Reset (rst_n=0 at a clk edge, including mid-operation):
  - state=IDLE; all outputs 0; pos=0; tick_pend=0; prescaler=0; stop_pend=0.
  - An outstanding upd_req is dropped. An upd_ack arriving later is ignored.
- FSM states: IDLE, READ, LATCH, SHIFT, UPDATE, WAIT_TICK.
- IDLE:
  - start=1 and msg_len!=0: latch msg_len and dir_in (dir_in becomes shift_dir), pos=0, clear overrun, clear prescaler, go to READ next cycle.
  - Otherwise stay in IDLE.
- Column position: pos counts 0 .. msg_len+GAP-1.
  - pos<msg_len: data column. mem_addr = pos (dir 0) or msg_len-1-pos (dir 1).
  - pos>=msg_len: gap column. No mem_rd; data = 8'h00.
- READ: mem_rd=1 for data columns only; 1 cycle; then LATCH.
- LATCH: shift_d <= mem_data, or 0 for a gap column; 1 cycle; then SHIFT.
- SHIFT:
  - shift_en=1 for exactly 1 cycle.
  - pos advances: pos==msg_len+GAP-1 gives pos=0 and wrap=1 in this same cycle.
  - Next state: UPDATE.
- UPDATE:
  - upd_req=1 until the cycle upd_ack=1 is sampled; upd_req=0 the next cycle.
  - Exit to IDLE if stop_pend is set (stop_pend then cleared), otherwise to WAIT_TICK.
- WAIT_TICK: on tick or tick_pend, clear tick_pend and go to READ.
- Timing:
  - start at edge k: mem_rd in cycle k+1, shift_en in k+3, upd_req from k+4.
  - Steady-state column period is CLK_DIV cycles, provided the serializer acks within CLK_DIV-4 cycles.
- Prescaler:
  - Free-running 0..CLK_DIV-1 while busy; tick is high when it equals CLK_DIV-1.
  - A tick outside WAIT_TICK sets tick_pend.
  - A tick while tick_pend is already 1 sets overrun; the tick is dropped.
- stop:
  - Latched into stop_pend in any busy state.
  - The current column completes through UPDATE, then IDLE.
  - stop in IDLE is ignored.
- Simultaneous events:
  - start and stop in the same IDLE cycle: start wins, stop ignored.
  - dir_in and msg_len changes while busy are ignored until the next start.

Test Plan:
- CLK_DIV=8, GAP=2, msg_len=3, mem[0..2]=A5,3C,FF, dir=0, ack after 1 cycle -> shift_d sequence A5,3C,FF,00,00,A5; wrap pulse at the 5th shift_en; shift_en spacing 8 cycles.
- Same setup with dir_in=1 -> mem_addr 2,1,0; shift_d FF,3C,A5,00,00; shift_dir=1 throughout.
- start with msg_len=0 -> busy stays 0, no mem_rd or shift_en.
- Hold upd_ack low 20 cycles with CLK_DIV=8 -> upd_req held 20 cycles; overrun=1; after ack, next READ occurs on the following cycle (pending tick).
- stop pulse during WAIT_TICK -> exactly one more shift_en and one upd_req/ack pair, then busy=0.
- rst_n low while upd_req=1 -> next cycle all outputs 0 and state IDLE; a following start restarts at pos 0.
